mem_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-ported unified word memory between the core's instruction-fetch port and its load/store port. Requests are granted one at a time; the arbiter drives the memory and tracks the single outstanding access through a fixed memory latency. It routes read data back to the owner and raises `stall` so the core holds its pipeline. It sits between the core (PC/fetch and the ALU-address data path) and the shared memory.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and defaults for the unified-memory arbiter.
//   owner_e : which port owns the single outstanding access
//   state_e : arbiter FSM states
//   GNT_IF/GNT_D : bit positions of the one-hot grant vector
//   sc_width() : width of the starvation counter for a given STARVE
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int MEM_LAT_DEF = 2;
    localparam int STARVE_DEF  = 3;

    localparam int GNT_IF = 0;
    localparam int GNT_D  = 1;

    // ceil(log2(STARVE+1)), never narrower than one bit
    function automatic int sc_width(input int starve);
        return (starve < 1) ? 1 : $clog2(starve + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core-side request/response and memory-side bus for the arbiter.
//   slave  : arbiter view (requests and mem_rdata in; grants, responses, memory strobes, stall out)
//   master : core + memory view (the opposite directions)
// Parameters: n = data width, AW = word address width.
interface mem_arbiter_if #(
    parameter int n  = 32,
    parameter int AW = 6
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [n-1:0]  if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [n-1:0]  d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [n-1:0]  d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [n-1:0]  mem_wdata;
    logic [n-1:0]  mem_rdata;

    logic          stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational priority pick between fetch and data requests.
//   if_req, d_req : raw requests
//   sc            : consecutive data grants taken while fetch was waiting
//   gnt           : one-hot pick (gnt[GNT_IF] / gnt[GNT_D]), zero when nothing requests
// Data normally wins (it belongs to the older instruction); once sc reaches
// STARVE a waiting fetch is let through.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE = STARVE_DEF,
    parameter int SCW    = sc_width(STARVE_DEF)
) (
    input  logic           if_req,
    input  logic           d_req,
    input  logic [SCW-1:0] sc,
    output logic [1:0]     gnt
);

    logic force_if;

    always_comb begin
        gnt      = 2'b00;
        force_if = if_req && (int'(sc) >= STARVE);
        if (d_req && !force_if)
            gnt[GNT_D] = 1'b1;
        else if (if_req)
            gnt[GNT_IF] = 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported word memory between instruction fetch
// and load/store. One access is outstanding at a time; it completes MEM_LAT
// cycles after its grant, when read data is routed to the owner.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (fetch port, data port, memory port, stall)
// Arbitration is Mealy: grant, mem_en, mem_addr/mem_we/mem_wdata assert in the
// same cycle as the winning request, either in IDLE or in the completing BUSY
// cycle so accesses can run back-to-back.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int n       = 32,
    parameter int AW      = 6,
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int STARVE  = STARVE_DEF
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int CW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SCW = sc_width(STARVE);

    state_e         state_q, state_d;
    owner_e         own_q, own_d;
    logic           wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SCW-1:0] sc_q, sc_d;

    logic [1:0] pick;
    logic       done, arb_ok, gnt_if, gnt_d, if_rv, d_rv, busy;

    mem_arb_pick #(.STARVE(STARVE), .SCW(SCW)) u_pick (
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .sc     (sc_q),
        .gnt    (pick)
    );

    // Everything is held quiet while rst is high so an abandoned access
    // cannot complete or re-arbitrate during the reset cycle.
    assign busy   = (state_q == ST_BUSY);
    assign done   = !rst && busy && (cnt_q == '0);
    assign arb_ok = !rst && (!busy || done);
    assign gnt_if = arb_ok && pick[GNT_IF];
    assign gnt_d  = arb_ok && pick[GNT_D];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            own_q   <= OWN_NONE;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        sc_d    = sc_q;

        if (busy && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;

        if (done) begin
            state_d = ST_IDLE;
            own_d   = OWN_NONE;
            wr_d    = 1'b0;
        end

        // A grant in the completing cycle overrides the return to IDLE.
        if (gnt_if) begin
            state_d = ST_BUSY;
            own_d   = OWN_IF;
            wr_d    = 1'b0;
            cnt_d   = CW'(MEM_LAT - 1);
            sc_d    = '0;
        end else if (gnt_d) begin
            state_d = ST_BUSY;
            own_d   = OWN_D;
            wr_d    = bus.d_we;
            cnt_d   = CW'(MEM_LAT - 1);
            // Count only grants that made a fetch wait; saturate at STARVE.
            if (!bus.if_req)
                sc_d = '0;
            else if (int'(sc_q) < STARVE)
                sc_d = sc_q + 1'b1;
        end
    end

    assign if_rv = done && (own_q == OWN_IF);
    assign d_rv  = done && (own_q == OWN_D);

    assign bus.if_gnt    = gnt_if;
    assign bus.d_gnt     = gnt_d;
    assign bus.if_rvalid = if_rv;
    assign bus.d_rvalid  = d_rv;
    assign bus.if_rdata  = if_rv ? bus.mem_rdata : {n{1'b0}};
    assign bus.d_rdata   = (d_rv && !wr_q) ? bus.mem_rdata : {n{1'b0}};

    assign bus.mem_en    = gnt_if || gnt_d;
    assign bus.mem_we    = gnt_d && bus.d_we;
    assign bus.mem_addr  = gnt_d ? bus.d_addr : (gnt_if ? bus.if_addr : {AW{1'b0}});
    assign bus.mem_wdata = (gnt_d && bus.d_we) ? bus.d_wdata : {n{1'b0}};

    // A fresh grant counts as outstanding unless a completion is delivered in
    // the same cycle; that keeps a MEM_LAT=1 back-to-back stream stall-free.
    assign bus.stall = !rst && ((bus.if_req && !gnt_if) ||
                                (bus.d_req  && !gnt_d)  ||
                                ((busy || gnt_if || gnt_d) && !done));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. dut0 runs MEM_LAT=2/STARVE=3,
// dut1 runs MEM_LAT=1 for the back-to-back fetch stream. Inputs change #1
// after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.n(32), .AW(6)) b0 ();
    mem_arbiter_if #(.n(32), .AW(6)) b1 ();

    mem_arbiter #(.n(32), .AW(6), .MEM_LAT(2), .STARVE(3)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    mem_arbiter #(.n(32), .AW(6), .MEM_LAT(1), .STARVE(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.if_req = 0; b0.if_addr = '0; b0.d_req = 0; b0.d_we = 0;
        b0.d_addr = '0; b0.d_wdata = '0; b0.mem_rdata = '0;
        b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0;
        b1.d_addr = '0; b1.d_wdata = '0; b1.mem_rdata = '0;

        // Reset state
        nxt(); nxt(); smp();
        chk("rst_stall",   b0.stall, 0);
        chk("rst_mem_en",  b0.mem_en, 0);
        chk("rst_if_gnt",  b0.if_gnt, 0);
        chk("rst_d_gnt",   b0.d_gnt, 0);
        chk("rst_if_rv",   b0.if_rvalid, 0);
        chk("rst_d_rv",    b0.d_rvalid, 0);
        chk("rst_sc",      dut0.sc_q, 0);
        nxt(); rst = 0; smp();
        chk("idle_stall",  b0.stall, 0);

        // 1: single fetch
        nxt(); b0.if_req = 1; b0.if_addr = 6'h05; smp();
        chk("t1_if_gnt",   b0.if_gnt, 1);
        chk("t1_mem_en",   b0.mem_en, 1);
        chk("t1_mem_addr", b0.mem_addr, 64'h05);
        chk("t1_mem_we",   b0.mem_we, 0);
        chk("t1_stall_T",  b0.stall, 1);
        nxt(); b0.if_req = 0; smp();
        chk("t1_gnt_T1",   b0.if_gnt, 0);
        chk("t1_rv_T1",    b0.if_rvalid, 0);
        chk("t1_stall_T1", b0.stall, 1);
        nxt(); b0.mem_rdata = 32'h00500093; smp();
        chk("t1_rvalid",   b0.if_rvalid, 1);
        chk("t1_rdata",    b0.if_rdata, 64'h00500093);
        chk("t1_stall_T2", b0.stall, 0);
        nxt(); b0.mem_rdata = '0; smp();
        chk("t1_rv_off",   b0.if_rvalid, 0);
        chk("t1_rdata_off", b0.if_rdata, 0);

        // 2: simultaneous fetch and load, data wins, fetch back-to-back
        nxt(); b0.if_req = 1; b0.if_addr = 6'h07;
        b0.d_req = 1; b0.d_we = 0; b0.d_addr = 6'h10; smp();
        chk("t2_d_gnt",    b0.d_gnt, 1);
        chk("t2_if_gnt",   b0.if_gnt, 0);
        chk("t2_mem_addr", b0.mem_addr, 64'h10);
        chk("t2_stall",    b0.stall, 1);
        nxt(); b0.d_req = 0; smp();
        chk("t2_if_wait",  b0.if_gnt, 0);
        chk("t2_stall_T1", b0.stall, 1);
        nxt(); b0.mem_rdata = 32'h11111111; smp();
        chk("t2_d_rv",     b0.d_rvalid, 1);
        chk("t2_d_rdata",  b0.d_rdata, 64'h11111111);
        chk("t2_if_gnt2",  b0.if_gnt, 1);
        chk("t2_if_addr",  b0.mem_addr, 64'h07);
        chk("t2_stall_T2", b0.stall, 0);
        nxt(); b0.if_req = 0; b0.mem_rdata = '0; smp();
        chk("t2_if_rv_T3", b0.if_rvalid, 0);
        chk("t2_stall_T3", b0.stall, 1);
        nxt(); b0.mem_rdata = 32'h22222222; smp();
        chk("t2_if_rv",    b0.if_rvalid, 1);
        chk("t2_if_rdata", b0.if_rdata, 64'h22222222);
        chk("t2_d_rv_off", b0.d_rvalid, 0);

        // 3: store
        nxt(); b0.mem_rdata = '0; b0.d_req = 1; b0.d_we = 1;
        b0.d_addr = 6'h3F; b0.d_wdata = 32'hDEADBEEF; smp();
        chk("t3_d_gnt",     b0.d_gnt, 1);
        chk("t3_mem_en",    b0.mem_en, 1);
        chk("t3_mem_we",    b0.mem_we, 1);
        chk("t3_mem_addr",  b0.mem_addr, 64'h3F);
        chk("t3_mem_wdata", b0.mem_wdata, 64'hDEADBEEF);
        nxt(); b0.d_req = 0; b0.d_we = 0; b0.d_wdata = '0; smp();
        chk("t3_stall_T1",  b0.stall, 1);
        nxt(); b0.mem_rdata = 32'h12345678; smp();
        chk("t3_d_rv",      b0.d_rvalid, 1);
        chk("t3_d_rdata",   b0.d_rdata, 0);

        // 4: starvation guard, arbitration every MEM_LAT=2 cycles
        nxt(); b0.mem_rdata = '0; b0.if_req = 1; b0.if_addr = 6'h02;
        b0.d_req = 1; b0.d_we = 0; b0.d_addr = 6'h01;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("t4_d_gnt",  b0.d_gnt,  (k < 3) ? 1 : 0);
            chk("t4_if_gnt", b0.if_gnt, (k == 3) ? 1 : 0);
            nxt(); smp();
            chk("t4_gap_gnt", {b0.if_gnt, b0.d_gnt}, 0);
            chk("t4_sc", dut0.sc_q, (k < 3) ? 64'(k + 1) : 64'd0);
            nxt();
        end
        smp();
        chk("t4_d_again", b0.d_gnt, 1);
        nxt(); b0.if_req = 0; b0.d_req = 0;
        nxt(); smp();
        chk("t4_d_rv", b0.d_rvalid, 1);

        // 5: reset in the middle of an access
        nxt(); b0.if_req = 1; b0.if_addr = 6'h0A; smp();
        chk("t5_if_gnt",   b0.if_gnt, 1);
        nxt(); b0.if_req = 0; rst = 1; smp();
        chk("t5_rst_stall", b0.stall, 0);
        chk("t5_rst_rv",    b0.if_rvalid, 0);
        chk("t5_rst_en",    b0.mem_en, 0);
        nxt(); rst = 0; b0.mem_rdata = 32'hBAD0BAD0; smp();
        chk("t5_no_rv",     b0.if_rvalid, 0);
        chk("t5_no_rdata",  b0.if_rdata, 0);
        chk("t5_stall",     b0.stall, 0);
        nxt(); b0.mem_rdata = '0; b0.d_req = 1; b0.d_we = 0; b0.d_addr = 6'h04; smp();
        chk("t5_d_gnt",     b0.d_gnt, 1);
        chk("t5_mem_addr",  b0.mem_addr, 64'h04);
        nxt(); b0.d_req = 0;
        nxt(); b0.mem_rdata = 32'h44; smp();
        chk("t5_d_rv",      b0.d_rvalid, 1);
        chk("t5_d_rdata",   b0.d_rdata, 64'h44);
        nxt(); b0.mem_rdata = '0;

        // 6: MEM_LAT=1 continuous fetch stream
        b1.if_req = 1; b1.if_addr = 6'h20; smp();
        chk("t6_first_gnt",   b1.if_gnt, 1);
        chk("t6_first_rv",    b1.if_rvalid, 0);
        chk("t6_first_stall", b1.stall, 1);
        for (int i = 1; i <= 4; i++) begin
            nxt(); b1.mem_rdata = 32'(256 + i); b1.if_addr = 6'(32 + i); smp();
            chk("t6_gnt",   b1.if_gnt, 1);
            chk("t6_rv",    b1.if_rvalid, 1);
            chk("t6_rdata", b1.if_rdata, 64'(256 + i));
            chk("t6_addr",  b1.mem_addr, 64'(32 + i));
            chk("t6_stall", b1.stall, 0);
        end
        nxt(); b1.if_req = 0; b1.mem_rdata = 32'h105; smp();
        chk("t6_last_rv",    b1.if_rvalid, 1);
        chk("t6_last_rdata", b1.if_rdata, 64'h105);
        chk("t6_last_gnt",   b1.if_gnt, 0);
        chk("t6_last_stall", b1.stall, 0);
        nxt(); b1.mem_rdata = '0; smp();
        chk("t6_idle_rv",    b1.if_rvalid, 0);
        chk("t6_idle_stall", b1.stall, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
